instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter OP_IN, default 6'h3C: opcode in instr[31:26] that marks an IN instruction.
REQ-002 SHALL have parameter OP_OUT, default 6'h3D: opcode that marks an OUT instruction.
REQ-003 SHALL have parameter OP_HLT, default 6'h3F: opcode that marks a halt instruction.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 pc_in  input  32  current PC from program counter.
REQ-008 imem_addr  output  32  instruction memory address; combinationally equals pc_in.
REQ-009 imem_rdata  input  32  instruction word; valid one cycle after the address is issued.
REQ-010 stall  input  1  decode backpressure; holds the presented instruction.
REQ-011 flush  input  1  discards the presented, buffered and in-flight instructions.
REQ-012 switch_io  input  1  operator confirm that releases an IO wait.
REQ-013 instr / instr_pc  output  32 each  presented instruction and its address.
REQ-014 instr_valid  output  1  instr holds a live instruction.
REQ-015 is_in / is_out  output  1 each  decode of the presented opcode, qualified by instr_valid.
REQ-016 io_wait / halted  output  1 each  state is IO_WAIT / HALT.
REQ-017 pc_hold  output  1  freezes the program counter: skid full, or state is not RUN, or stall with instr_valid.
REQ-018 fetch_count  output  32  and stall_cycles  output  16  performance counters (see Configuration).

Function
REQ-019 SHALL implement FSM states RUN, IO_WAIT and HALT.
REQ-020 RUN, pc_hold low: SHALL issue a request each cycle, registering req_pc=pc_in and setting inflight=1.
REQ-021 A returning word SHALL load instr/instr_pc and set instr_valid when stall is low or instr_valid is 0; otherwise it SHALL enter the 1-entry skid buffer.
REQ-022 When stall drops with skid full, the skid entry SHALL load into instr on that edge, before any new return; no return SHALL be lost or duplicated.
REQ-023 instr_valid SHALL clear on an edge where stall is low and nothing loads.
REQ-024 Loading an OP_IN/OP_OUT word SHALL move RUN->IO_WAIT on the same edge; loading OP_HLT SHALL move RUN->HALT.
REQ-025 IO_WAIT SHALL return to RUN on the edge switch_io is sampled high; fetching resumes the next cycle.
REQ-026 switch_io SHALL be ignored in RUN and HALT.
REQ-027 flush SHALL clear instr_valid, skid and inflight on the edge it is sampled, and move IO_WAIT->RUN.
REQ-028 flush SHALL have priority over stall, over switch_io, and over any simultaneous return.
REQ-029 HALT SHALL be left only by reset; no requests are issued and flush is ignored.
REQ-030 Latency: issue at edge N; instr_valid at edge N+1 when not stalled.

Reset
REQ-031 Reset SHALL asynchronously set: state=RUN; instr=0; instr_pc=0; instr_valid=0; skid empty; inflight=0; counters=0.
REQ-032 Resulting outputs: io_wait=0, halted=0, pc_hold=0.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight return.
REQ-034 The first request SHALL issue on the first edge after reset deasserts.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN defined: fetch_count SHALL increment per instruction loaded into instr and wrap at 2^32.
REQ-036 Macro FETCH_PERF_CNT_EN defined: stall_cycles SHALL increment per cycle with stall and instr_valid both high, saturating at 16'hFFFF.
REQ-037 Macro FETCH_PERF_CNT_EN undefined: both counter ports SHALL remain present and be driven constant 0, with no counter flops.

Verification
REQ-038 Reset, pc_in=1 then 2, imem returns 0x20010005 then 0x20020007 -> instr_valid high at edge 2 with instr_pc=1, then instr_pc=2; pc_hold=0.
REQ-039 stall high 3 cycles while instr_valid=1 -> instr held, second word in skid, pc_hold=1; stall low -> skid word presented next edge, none lost.
REQ-040 OUT word 0xF4000000 loaded -> io_wait=1, is_out=1, pc_hold=1 until switch_io pulses; fetch resumes the following cycle.
REQ-041 flush and switch_io both high in IO_WAIT -> state RUN, instr_valid=0 and skid empty on that edge.
REQ-042 HLT word 0xFC000000 loaded -> halted=1, flush has no effect; reset -> all outputs 0.
REQ-043 With FETCH_PERF_CNT_EN, 10 loads and 4 stalled cycles -> fetch_count=10, stall_cycles=4; without it -> both 0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one-cycle memory return, 1-entry skid buffer, RUN/IO_WAIT/HALT control.
// Define FETCH_PERF_CNT_EN to build the fetch_count / stall_cycles performance counters.
module instr_fetch_stage #(
  parameter logic [5:0] OP_IN  = 6'h3C,
  parameter logic [5:0] OP_OUT = 6'h3D,
  parameter logic [5:0] OP_HLT = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        switch_io,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        is_in,
  output logic        is_out,
  output logic        io_wait,
  output logic        halted,
  output logic        pc_hold,
  output logic [31:0] fetch_count,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {S_RUN, S_IO_WAIT, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_full_q, skid_full_d;
  logic        inflight_q, inflight_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic        hold_instr;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] load_pc;

  assign imem_addr  = pc_in;
  assign pc_hold    = skid_full_q | (state_q != S_RUN) | (stall & valid_q);
  // Outside RUN the presented word is frozen exactly as if decode were stalling.
  assign hold_instr = stall | (state_q != S_RUN);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    valid_d     = valid_q;
    skid_d      = skid_q;
    skid_pc_d   = skid_pc_q;
    skid_full_d = skid_full_q;
    inflight_d  = 1'b0;
    req_pc_d    = req_pc_q;
    load        = 1'b0;
    load_word   = imem_rdata;
    load_pc     = req_pc_q;

    if (state_q == S_HALT) begin
      // Only reset leaves HALT; any late return is simply dropped.
    end else if (flush) begin
      valid_d     = 1'b0;
      skid_full_d = 1'b0;
      state_d     = S_RUN;
    end else begin
      if (skid_full_q && !hold_instr) begin
        // The buffered word goes first; a simultaneous return takes its place.
        load        = 1'b1;
        load_word   = skid_q;
        load_pc     = skid_pc_q;
        skid_full_d = inflight_q;
        if (inflight_q) begin
          skid_d    = imem_rdata;
          skid_pc_d = req_pc_q;
        end
      end else if (inflight_q) begin
        if (!hold_instr || !valid_q) begin
          load = 1'b1;
        end else begin
          skid_full_d = 1'b1;
          skid_d      = imem_rdata;
          skid_pc_d   = req_pc_q;
        end
      end else if (!hold_instr) begin
        valid_d = 1'b0;
      end

      if (load) begin
        instr_d    = load_word;
        instr_pc_d = load_pc;
        valid_d    = 1'b1;
        if (state_q == S_RUN) begin
          case (load_word[31:26])
            OP_IN, OP_OUT: state_d = S_IO_WAIT;
            OP_HLT:        state_d = S_HALT;
            default:       state_d = S_RUN;
          endcase
        end
      end

      if (state_q == S_IO_WAIT && switch_io) state_d = S_RUN;

      if (!pc_hold) begin
        inflight_d = 1'b1;
        req_pc_d   = pc_in;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      valid_q     <= 1'b0;
      skid_full_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      valid_q     <= valid_d;
      skid_full_q <= skid_full_d;
      inflight_q  <= inflight_d;
    end
  end

  // NOTE: payload registers are qualified by skid_full_q / inflight_q, so they carry no reset.
  always_ff @(posedge clk) begin
    skid_q    <= skid_d;
    skid_pc_q <= skid_pc_d;
    req_pc_q  <= req_pc_d;
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign is_in       = valid_q & (instr_q[31:26] == OP_IN);
  assign is_out      = valid_q & (instr_q[31:26] == OP_OUT);
  assign io_wait     = (state_q == S_IO_WAIT);
  assign halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall && valid_q && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign stall_cycles = stall_cnt_q;
`else
  assign fetch_count  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: queue-based reference model, randomized and directed stimulus.
module tb_instr_fetch_stage;

  localparam logic [5:0] OP_IN  = 6'h3C;
  localparam logic [5:0] OP_OUT = 6'h3D;
  localparam int M_RUN = 0;
  localparam int M_IOW = 1;
  localparam int M_HLT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        switch_io = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, is_in, is_out, io_wait, halted, pc_hold;
  logic [31:0] fetch_count;
  logic [15:0] stall_cycles;

  instr_fetch_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .switch_io(switch_io), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .is_in(is_in), .is_out(is_out), .io_wait(io_wait),
    .halted(halted), .pc_hold(pc_hold), .fetch_count(fetch_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; logic [31:0] pc; bit arrived; } ent_t;
  typedef struct { logic [31:0] word; logic [31:0] pc; } exp_t;

  logic [31:0] mem [256];
  ent_t        mq[$];      // outstanding instructions, oldest first
  exp_t        exp_q[$];   // scoreboard of words decode should receive, in order
  int          m_st;
  bit          m_p;        // oldest outstanding word is the one being presented
  bit          m_infl;     // newest outstanding word has not returned yet
  logic [31:0] pc_model;
  int          m_loads, m_stalls;
  int          n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_skid_full();
    return m_p && mq.size() > 1 && mq[1].arrived;
  endfunction

  function automatic logic [31:0] rand_word();
    int unsigned r = $urandom_range(0, 99);
    logic [31:0] w = $urandom();
    if (r < 8)       w[31:26] = OP_IN;
    else if (r < 16) w[31:26] = OP_OUT;
    else             w[31:26] = 6'($urandom_range(0, 59));
    return w;
  endfunction

  task automatic model_clear(input logic [31:0] pc);
    mq.delete();
    exp_q.delete();
    m_st = M_RUN; m_p = 0; m_infl = 0;
    m_loads = 0; m_stalls = 0;
    pc_model = pc;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; switch_io = 1'b0;
    #1;
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_io_wait", 32'(io_wait), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_pc_hold", 32'(pc_hold), 32'h0);
    check("rst_is_in_out", 32'({is_in, is_out}), 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_stall_cycles", 32'(stall_cycles), 32'h0);
    model_clear(pc);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock: drive inputs after the falling edge, check the model's view, then advance the model
  // to what the next rising edge must produce.
  task automatic cycle(input bit s, input bit f, input bit sw, input logic [31:0] redir);
    bit   hold;
    int   old_st;
    ent_t ne;
    exp_t ee;
    @(negedge clk);
    imem_rdata = mem[imem_addr[7:0]];
    pc_in = pc_model; stall = s; flush = f; switch_io = sw;
    #1;
    hold = m_skid_full() || (m_st != M_RUN) || (s && m_p);
    check("pc_hold", 32'(pc_hold), 32'(hold));
    check("imem_addr", imem_addr, pc_in);
    check("instr_valid", 32'(instr_valid), 32'(m_p));
    check("io_wait", 32'(io_wait), 32'(m_st == M_IOW));
    check("halted", 32'(halted), 32'(m_st == M_HLT));
    if (m_p) begin
      check("is_in", 32'(is_in), 32'(mq[0].word[31:26] == OP_IN));
      check("is_out", 32'(is_out), 32'(mq[0].word[31:26] == OP_OUT));
    end else begin
      check("is_in_out_idle", 32'({is_in, is_out}), 32'h0);
    end
    if (s && m_p && m_stalls < 65535) m_stalls++;

    if (m_st == M_HLT) begin
      m_infl = 0;
    end else if (f) begin
      mq.delete(); exp_q.delete();
      m_p = 0; m_infl = 0; m_st = M_RUN;
      pc_model = redir;
    end else begin
      old_st = m_st;
      if (m_p && old_st == M_RUN && !s) begin
        void'(mq.pop_front());
        m_p = 0;
      end
      if (m_infl) mq[mq.size()-1].arrived = 1'b1;
      if (!m_p && mq.size() > 0 && mq[0].arrived) begin
        m_p = 1;
        m_loads++;
        if (old_st == M_RUN) begin
          if (mq[0].word[31:26] == OP_IN || mq[0].word[31:26] == OP_OUT) m_st = M_IOW;
          else if (mq[0].word[31:26] == 6'h3F) m_st = M_HLT;
        end
      end
      if (old_st == M_IOW && sw) m_st = M_RUN;
      m_infl = !hold;
      if (!hold) begin
        ne.word = mem[pc_model[7:0]]; ne.pc = pc_model; ne.arrived = 1'b0;
        ee.word = ne.word; ee.pc = ne.pc;
        mq.push_back(ne);
        exp_q.push_back(ee);
        pc_model = pc_model + 32'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_counters(input string tag);
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_fetch_count"}, fetch_count, 32'(m_loads));
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
`else
    check({tag, "_fetch_count"}, fetch_count, 32'h0);
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'h0);
`endif
  endtask

  // Monitor: each word decode accepts is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && instr_valid && !stall && !flush && !io_wait && !halted) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb_underflow: DUT presented %h at pc %h, expected nothing", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", instr, e.word);
          check("sb_instr_pc", instr_pc, e.pc);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[1]  = 32'h2001_0005;
    mem[2]  = 32'h2002_0007;
    mem[40] = 32'hF400_0000;
    mem[50] = 32'hF000_0000;
    mem[60] = 32'hFC00_0000;

    do_reset(32'd1);
    idle(3);
    check("dir_first_pc", instr_pc, 32'd1);
    check("dir_first_word", instr, 32'h2001_0005);
    idle(1);
    check("dir_second_pc", instr_pc, 32'd2);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("dir_stall_held_pc", instr_pc, 32'd3);
    check("dir_stall_pc_hold", 32'(pc_hold), 32'h1);
    idle(2);
    check("dir_skid_released_pc", instr_pc, 32'd4);
    check_counters("dir_mid");

    cycle(1'b0, 1'b1, 1'b0, 32'd40);
    idle(3);
    check("dir_out_io_wait", 32'(io_wait), 32'h1);
    check("dir_out_is_out", 32'(is_out), 32'h1);
    check("dir_out_pc_hold", 32'(pc_hold), 32'h1);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    idle(1);
    check("dir_out_released", 32'(io_wait), 32'h0);
    idle(1);
    check("dir_fetch_resumed", 32'(pc_hold), 32'h0);
    idle(3);

    cycle(1'b0, 1'b1, 1'b0, 32'd50);
    idle(3);
    check("dir_in_is_in", 32'(is_in), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'd55);
    idle(1);
    check("dir_flush_sw_state", 32'(io_wait), 32'h0);
    check("dir_flush_sw_valid", 32'(instr_valid), 32'h0);
    check("dir_flush_sw_skid", 32'(pc_hold), 32'h0);
    idle(4);

    cycle(1'b0, 1'b1, 1'b0, 32'd60);
    idle(3);
    check("dir_hlt_halted", 32'(halted), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'd0);
    idle(2);
    check("dir_hlt_flush_ignored", 32'(halted), 32'h1);
    check("dir_hlt_instr", instr, 32'hFC00_0000);
    check_counters("dir_end");

    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    do_reset(32'($urandom_range(0, 255)));
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        check_counters("rand_mid");
        do_reset(32'($urandom_range(0, 255)));
      end
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 25, 32'($urandom_range(0, 255)));
    end
    idle(2);
    check_counters("rand_end");
    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
